// File: rtl/hgc_vram_arbiter_pkg.sv
// hgc VRAM arbiter shared types.
// State encoding and SRAM geometry.
package hgc_vram_arbiter_pkg;

  localparam int RAM_AW = 19;
  localparam int RAM_DW = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RDONE   = 3'd2,
    ST_WSETUP  = 3'd3,
    ST_WSTROBE = 3'd4,
    ST_WHOLD   = 3'd5
  } state_e;

endpackage

// File: rtl/hgc_vram_arbiter_if.sv
// hgc VRAM arbiter requester bus.
// CPU and video request/ack ports.
interface hgc_vram_arbiter_if
  import hgc_vram_arbiter_pkg::*;
  ;

  logic              cpu_req;
  logic              cpu_we;
  logic [RAM_AW-1:0] cpu_addr;
  logic [RAM_DW-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [RAM_DW-1:0] cpu_rdata;
  logic              vid_req;
  logic [RAM_AW-1:0] vid_addr;
  logic              vid_ack;
  logic [RAM_DW-1:0] vid_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output vid_req, vid_addr,
    input  cpu_ack, cpu_rdata, vid_ack, vid_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  vid_req, vid_addr,
    output cpu_ack, cpu_rdata, vid_ack, vid_rdata
  );

endinterface

// File: rtl/hgc_vram_arbiter.sv
// hgc VRAM arbiter: video-priority SRAM sharing
// with a CPU starvation guard and SRAM timing.
module hgc_vram_arbiter
  import hgc_vram_arbiter_pkg::*;
#(
  parameter int RD_WAIT      = 2,
  parameter int WR_PULSE     = 2,
  parameter int CPU_MAX_SKIP = 3
) (
  input  logic              clk,
  input  logic              busreset,
  hgc_vram_arbiter_if.slave bus,
  output logic [RAM_AW-1:0] ram_a,
  input  logic [RAM_DW-1:0] ram_d_in,
  output logic [RAM_DW-1:0] ram_d_out,
  output logic              ram_d_oe,
  output logic              ram_we_l
);

  localparam logic [2:0] RD_LAST  = 3'(RD_WAIT - 1);
  localparam logic [2:0] WR_LAST  = 3'(WR_PULSE - 1);
  localparam logic [3:0] SKIP_MAX = 4'(CPU_MAX_SKIP);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              own_cpu_q, own_cpu_d;
  logic [3:0]        skip_q, skip_d;
  logic              grant_vid, grant_cpu, cap;

  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [RAM_DW-1:0] wdat_q, wdat_d;
  logic              we_l_q, we_l_d;
  logic              oe_q, oe_d;
  logic              cack_q, cack_d;
  logic              vack_q, vack_d;
  logic [RAM_DW-1:0] crd_q, crd_d;
  logic [RAM_DW-1:0] vrd_q, vrd_d;

  // Control state: FSM, shared timing counter, owner, skip.
  always_ff @(posedge clk) begin
    if (busreset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      own_cpu_q <= 1'b0;
      skip_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      own_cpu_q <= own_cpu_d;
      skip_q    <= skip_d;
    end
  end

  // Arbitration in IDLE and transaction sequencing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    own_cpu_d = own_cpu_q;
    skip_d    = skip_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        grant_vid = bus.vid_req &&
                    !(bus.cpu_req && skip_q == SKIP_MAX);
        grant_cpu = !grant_vid && bus.cpu_req;
        if (!bus.cpu_req) skip_d = '0;
        unique case (1'b1)
          grant_vid: begin
            state_d   = ST_RD;
            own_cpu_d = 1'b0;
            addr_d    = bus.vid_addr;
            if (bus.cpu_req && skip_q != SKIP_MAX)
              skip_d = skip_q + 4'd1;
          end
          grant_cpu: begin
            own_cpu_d = 1'b1;
            addr_d    = bus.cpu_addr;
            skip_d    = '0;
            if (bus.cpu_we) begin
              state_d = ST_WSETUP;
              wdat_d  = bus.cpu_wdata;
            end else begin
              state_d = ST_RD;
            end
          end
          default: ;
        endcase
      end
      ST_RD: begin
        if (cnt_q == RD_LAST) begin
          state_d = ST_RDONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_RDONE:  state_d = ST_IDLE;
      ST_WSETUP: begin
        state_d = ST_WSTROBE;
        cnt_d   = '0;
      end
      ST_WSTROBE: begin
        if (cnt_q == WR_LAST) begin
          state_d = ST_WHOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_WHOLD:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Pin and ack values for the next state, so they
  // leave flops cleanly; read data captured on last RD.
  always_comb begin
    we_l_d = (state_d != ST_WSTROBE);
    oe_d   = (state_d == ST_WSETUP) ||
             (state_d == ST_WSTROBE) ||
             (state_d == ST_WHOLD);
    cack_d = (state_d == ST_WHOLD) ||
             (state_d == ST_RDONE && own_cpu_d);
    vack_d = (state_d == ST_RDONE) && !own_cpu_d;
    cap    = (state_q == ST_RD) && (cnt_q == RD_LAST);
    crd_d  = (cap && own_cpu_q)  ? ram_d_in : crd_q;
    vrd_d  = (cap && !own_cpu_q) ? ram_d_in : vrd_q;
  end

  // Registered SRAM pins, acks and read data.
  always_ff @(posedge clk) begin
    if (busreset) begin
      addr_q <= '0;
      wdat_q <= '0;
      we_l_q <= 1'b1;
      oe_q   <= 1'b0;
      cack_q <= 1'b0;
      vack_q <= 1'b0;
      crd_q  <= '0;
      vrd_q  <= '0;
    end else begin
      addr_q <= addr_d;
      wdat_q <= wdat_d;
      we_l_q <= we_l_d;
      oe_q   <= oe_d;
      cack_q <= cack_d;
      vack_q <= vack_d;
      crd_q  <= crd_d;
      vrd_q  <= vrd_d;
    end
  end

  assign ram_a         = addr_q;
  assign ram_d_out     = wdat_q;
  assign ram_d_oe      = oe_q;
  assign ram_we_l      = we_l_q;
  assign bus.cpu_ack   = cack_q;
  assign bus.vid_ack   = vack_q;
  assign bus.cpu_rdata = crd_q;
  assign bus.vid_rdata = vrd_q;

endmodule

// File: tb/tb_hgc_vram_arbiter.sv
// Bench for hgc_vram_arbiter: SRAM model plus
// per-port scoreboards of expected acks and data.
module tb_hgc_vram_arbiter;

  logic        clk = 1'b0;
  logic        busreset;
  logic [18:0] ram_a;
  logic [7:0]  ram_d_in = 8'h00;
  logic [7:0]  ram_d_out;
  logic        ram_d_oe;
  logic        ram_we_l;

  hgc_vram_arbiter_if bus ();

  hgc_vram_arbiter dut (
    .clk      (clk),
    .busreset (busreset),
    .bus      (bus),
    .ram_a    (ram_a),
    .ram_d_in (ram_d_in),
    .ram_d_out(ram_d_out),
    .ram_d_oe (ram_d_oe),
    .ram_we_l (ram_we_l)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [18:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t        cpu_sb[$];
  exp_t        vid_sb[$];
  logic [7:0]  sram[logic [18:0]];
  logic [7:0]  exp_mem[logic [18:0]];
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  logic        rst_seen = 1'b1;
  logic        prev_oe  = 1'b0;
  logic        prev_we  = 1'b1;

  // Background contents; address 0x00123 holds 8'hA5.
  function automatic logic [7:0] pat(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'h87;
  endfunction

  function automatic logic [7:0] exp_rd(input logic [18:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : pat(a);
  endfunction

  function automatic logic [7:0] sram_rd(input logic [18:0] a);
    return sram.exists(a) ? sram[a] : pat(a);
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= busreset;
    if (!ram_we_l) sram[ram_a] = ram_d_out;
  end

  always @(negedge clk) ram_d_in <= sram_rd(ram_a);

  // Scoreboard pops and bus-safety checks.
  always @(negedge clk) begin
    exp_t e;
    if (bus.cpu_ack) begin
      if (cpu_sb.size() == 0) begin
        check("cpu_spurious_ack", 32'd1, 32'd0);
      end else begin
        e = cpu_sb.pop_front();
        if (e.we)
          check("cpu_wr_mem", 32'(sram_rd(e.addr)), 32'(e.data));
        else
          check("cpu_rdata", 32'(bus.cpu_rdata), 32'(e.data));
      end
    end
    if (bus.vid_ack) begin
      if (vid_sb.size() == 0) begin
        check("vid_spurious_ack", 32'd1, 32'd0);
      end else begin
        e = vid_sb.pop_front();
        check("vid_rdata", 32'(bus.vid_rdata), 32'(e.data));
      end
    end
    if (!rst_seen) begin
      check("we_without_oe", 32'(!ram_we_l && !ram_d_oe), 32'd0);
      check("turnaround",
            32'((ram_d_oe != prev_oe) && (ram_we_l != prev_we)), 32'd0);
    end
    prev_oe = ram_d_oe;
    prev_we = ram_we_l;
  end

  task automatic cpu_go(input logic we, input logic [18:0] a,
                        input logic [7:0] d, output int lat);
    exp_t e;
    int   t0;
    bit   got;
    e.we   = we;
    e.addr = a;
    e.data = we ? d : exp_rd(a);
    if (we) exp_mem[a] = d;
    cpu_sb.push_back(e);
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_req   = 1'b1;
    t0  = cyc;
    got = 0;
    lat = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.cpu_ack) begin
        got = 1;
        lat = cyc - t0;
      end
    end
    bus.cpu_req = 1'b0;
    if (!got) check("cpu_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic vid_go(input logic [18:0] a, output int lat);
    exp_t e;
    int   t0;
    bit   got;
    e.we   = 1'b0;
    e.addr = a;
    e.data = exp_rd(a);
    vid_sb.push_back(e);
    bus.vid_addr = a;
    bus.vid_req  = 1'b1;
    t0  = cyc;
    got = 0;
    lat = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.vid_ack) begin
        got = 1;
        lat = cyc - t0;
      end
    end
    bus.vid_req = 1'b0;
    if (!got) check("vid_ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int   lat, lat2, nv;
    bit   got;
    exp_t e;
    busreset      = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.vid_req   = 1'b0;
    bus.vid_addr  = '0;
    repeat (3) @(negedge clk);
    check("rst_we_l", 32'(ram_we_l), 32'd1);
    check("rst_oe", 32'(ram_d_oe), 32'd0);
    check("rst_ram_a", 32'(ram_a), 32'd0);
    check("rst_d_out", 32'(ram_d_out), 32'd0);
    check("rst_acks", 32'({bus.cpu_ack, bus.vid_ack}), 32'd0);
    check("rst_rdata", 32'({bus.cpu_rdata, bus.vid_rdata}), 32'd0);
    busreset = 1'b0;
    @(negedge clk);

    // 1: lone video read
    fork
      vid_go(19'h00123, lat);
      begin
        @(negedge clk);
        check("t1_ram_a", 32'(ram_a), 32'h123);
      end
    join
    check("t1_lat", 32'(lat), 32'd3);
    check("t1_rdata", 32'(bus.vid_rdata), 32'hA5);
    @(negedge clk);

    // 2: CPU write timing at the top address
    fork
      cpu_go(1'b1, 19'h7FFFF, 8'h3C, lat);
      for (int i = 1; i <= 5; i++) begin
        @(negedge clk);
        check($sformatf("t2_we_l_%0d", i), 32'(ram_we_l),
              32'(!(i == 2 || i == 3)));
        check($sformatf("t2_oe_%0d", i), 32'(ram_d_oe), 32'(i <= 4));
        if (i <= 4) check($sformatf("t2_a_%0d", i), 32'(ram_a), 32'h7FFFF);
      end
    join
    check("t2_lat", 32'(lat), 32'd4);
    check("t2_mem", 32'(sram_rd(19'h7FFFF)), 32'h3C);

    // 3: contention with video held; CPU on the fourth grant
    for (int r = 0; r < 2; r++) begin
      e.we   = 1'b0;
      e.addr = 19'h00200;
      e.data = exp_rd(19'h00200);
      repeat (3) vid_sb.push_back(e);
      e.addr = 19'h00300;
      e.data = exp_rd(19'h00300);
      cpu_sb.push_back(e);
      bus.vid_addr = 19'h00200;
      bus.cpu_addr = 19'h00300;
      bus.cpu_we   = 1'b0;
      bus.vid_req  = 1'b1;
      bus.cpu_req  = 1'b1;
      nv  = 0;
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk);
        if (bus.vid_ack) nv++;
        if (bus.cpu_ack) got = 1;
      end
      bus.vid_req = 1'b0;
      bus.cpu_req = 1'b0;
      check("t3_cpu_ack", 32'(got), 32'd1);
      check("t3_vid_grants", 32'(nv), 32'd3);
      @(negedge clk);
    end

    // 4: back-to-back write then read, one IDLE gap
    cpu_go(1'b1, 19'h12345, 8'h5A, lat);
    cpu_go(1'b0, 19'h12345, 8'h00, lat2);
    check("t4_wr_lat", 32'(lat), 32'd4);
    check("t4_rd_lat", 32'(lat2), 32'd4);
    check("t4_rdata", 32'(bus.cpu_rdata), 32'h5A);
    @(negedge clk);

    // 5: reset during the write strobe
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 19'h7FFF0;
    bus.cpu_wdata = 8'h99;
    bus.cpu_req   = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_strobe", 32'(ram_we_l), 32'd0);
    busreset    = 1'b1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check("t5_we_l", 32'(ram_we_l), 32'd1);
    check("t5_oe", 32'(ram_d_oe), 32'd0);
    check("t5_ack", 32'(bus.cpu_ack), 32'd0);
    check("t5_ram_a", 32'(ram_a), 32'd0);
    busreset = 1'b0;
    repeat (4) @(negedge clk);
    vid_go(19'h00050, lat);
    check("t5_idle_lat", 32'(lat), 32'd3);

    // 6: random concurrent traffic
    fork
      for (int k = 0; k < 30; k++) begin
        logic        we;
        logic [18:0] a;
        int          l;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        we = 1'($urandom_range(0, 1));
        if (we || $urandom_range(0, 1) == 1)
          a = 19'h40000 | 19'($urandom_range(0, 15));
        else
          a = 19'($urandom_range(0, 32'h3FFFF));
        cpu_go(we, a, 8'($urandom_range(0, 255)), l);
      end
      for (int k = 0; k < 30; k++) begin
        int l;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        vid_go(19'($urandom_range(0, 32'h3FFFF)), l);
      end
    join
    repeat (3) @(negedge clk);
    check("cpu_sb_empty", 32'(cpu_sb.size()), 32'd0);
    check("vid_sb_empty", 32'(vid_sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
